// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the register file
package regfile_pkg;

  localparam int RF_RESET_VAL = 0;

  function automatic int rf_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB index of field p in a packed bus of w-bit fields
  function automatic int rf_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - selects one WIDTH-bit field out of N packed fields
module mux_nto1
  import regfile_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  N     = 32,
  localparam int SW    = rf_addr_w(N)
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SW-1:0]      sel_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SW'(i)) data_o = data_i[rf_lo(i, WIDTH) +: WIDTH];
    end
  end

endmodule

// File: rtl/regfile_nr1w.sv
// rtl/regfile_nr1w.sv - NUM_REGS x WIDTH register file, NUM_RD read ports, one write port
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  parameter int  READ_REG = 0,
  localparam int AW       = rf_addr_w(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);

  localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RF_RESET_VAL);

  logic [NUM_REGS*WIDTH-1:0] mem_q;
  logic [NUM_REGS*WIDTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_addr == AW'(i)) && !((ZERO_REG != 0) && (i == 0)))
        mem_d[rf_lo(i, WIDTH) +: WIDTH] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= {NUM_REGS{RST_WORD}};
    else        mem_q <= mem_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] v;

    assign addr = rd_addr[rf_lo(p, AW) +: AW];

    mux_nto1 #(
      .WIDTH (WIDTH),
      .N     (NUM_REGS)
    ) u_mux (
      .data_i (mem_q),
      .sel_i  (addr),
      .data_o (mux_out)
    );

    // Hardwired zero wins over forwarding of a dropped write to entry 0
    assign v = ((ZERO_REG != 0) && (addr == '0))                 ? '0      :
               ((BYPASS != 0) && wr_en && (addr == wr_addr))     ? wr_data :
                                                                   mux_out;

    if (READ_REG != 0) begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= RST_WORD;
        else        rd_q <= v;
      end
      assign rd_data[rf_lo(p, WIDTH) +: WIDTH] = rd_q;
    end else begin : g_comb
      assign rd_data[rf_lo(p, WIDTH) +: WIDTH] = v;
    end
  end

endmodule

// File: tb/tb_regfile_nr1w.sv
// tb/tb_regfile_nr1w.sv - directed and random checks of regfile_nr1w over four parameter sets
module tb_regfile_nr1w;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en;
  logic [7:0]  wa;
  logic [31:0] wd;
  logic [7:0]  ra [4];
  logic [63:0] rd_a, rd_b, rd_c;
  logic [7:0]  rd_d;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [15:0] mc [8];
  logic [7:0]  md [256];
  logic [15:0] exp_c [4];

  always #5 clk = ~clk;

  regfile_nr1w u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa[4:0]), .wr_data(wd),
    .rd_addr({ra[1][4:0], ra[0][4:0]}), .rd_data(rd_a)
  );

  regfile_nr1w #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa[4:0]), .wr_data(wd),
    .rd_addr({ra[1][4:0], ra[0][4:0]}), .rd_data(rd_b)
  );

  regfile_nr1w #(.WIDTH(16), .NUM_REGS(8), .NUM_RD(4), .READ_REG(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa[2:0]), .wr_data(wd[15:0]),
    .rd_addr({ra[3][2:0], ra[2][2:0], ra[1][2:0], ra[0][2:0]}), .rd_data(rd_c)
  );

  regfile_nr1w #(.WIDTH(8), .NUM_REGS(256), .NUM_RD(1)) u_d (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd[7:0]),
    .rd_addr(ra[0]), .rd_data(rd_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ea(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en && (a == wa[4:0])) return wd;
    return ma[a];
  endfunction

  function automatic logic [15:0] ec(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (wr_en && (a == wa[2:0])) return wd[15:0];
    return mc[a];
  endfunction

  function automatic logic [7:0] ed(input logic [7:0] a);
    if (a == 8'd0) return 8'h0;
    if (wr_en && (a == wa)) return wd[7:0];
    return md[a];
  endfunction

  task automatic set_in(input logic en, input logic [7:0] a, input logic [31:0] d,
                        input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3);
    wr_en = en; wa = a; wd = d;
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin ma[i] = '0; mb[i] = '0; end
    for (int i = 0; i < 8; i++) mc[i] = '0;
    for (int i = 0; i < 256; i++) md[i] = '0;
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
  endtask

  task automatic pre_edge();
    #2;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("a%0d", p), rd_a[p*32 +: 32], ea(ra[p][4:0]));
      check($sformatf("b%0d", p), rd_b[p*32 +: 32], mb[ra[p][4:0]]);
    end
    check("d0", {24'h0, rd_d}, {24'h0, ed(ra[0])});
    for (int p = 0; p < 4; p++) exp_c[p] = ec(ra[p][2:0]);
    if (wr_en) begin
      if (wa[4:0] != 5'd0) ma[wa[4:0]] = wd;
      mb[wa[4:0]] = wd;
      if (wa[2:0] != 3'd0) mc[wa[2:0]] = wd[15:0];
      if (wa != 8'd0) md[wa] = wd[7:0];
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("c%0d", p), {16'h0, rd_c[p*16 +: 16]}, {16'h0, exp_c[p]});
  endtask

  task automatic check_zero(input string tag);
    for (int p = 0; p < 2; p++) begin
      check({tag, "_a"}, rd_a[p*32 +: 32], 32'h0);
      check({tag, "_b"}, rd_b[p*32 +: 32], 32'h0);
    end
    for (int p = 0; p < 4; p++) check({tag, "_c"}, {16'h0, rd_c[p*16 +: 16]}, 32'h0);
    check({tag, "_d"}, {24'h0, rd_d}, 32'h0);
  endtask

  initial begin
    clear_models();
    set_in(1'b0, 8'd0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 8'(i), 32'h1000_0000 + 32'(i), 8'(i), 8'(i - 1), 8'(i), 8'(i));
      pre_edge();
      post_edge();
    end
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 8'd0, 32'h0, 8'(i), 8'(31 - i), 8'(i), 8'(i));
      pre_edge();
      check("rdall0", rd_a[31:0],  (i == 0)  ? 32'h0 : 32'h1000_0000 + 32'(i));
      check("rdall1", rd_a[63:32], (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i));
      post_edge();
    end

    set_in(1'b1, 8'd0, 32'hFFFF_FFFF, 8'd0, 8'd0, 8'd0, 8'd0);
    pre_edge();
    check("zr_a_same", rd_a[31:0], 32'h0);
    check("zr_b_same", rd_b[31:0], 32'h0);
    post_edge();
    set_in(1'b0, 8'd0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    pre_edge();
    check("zr_a_next", rd_a[31:0], 32'h0);
    check("zr_b_next", rd_b[31:0], 32'hFFFF_FFFF);
    post_edge();

    set_in(1'b1, 8'd7, 32'h1234_5678, 8'd0, 8'd7, 8'd0, 8'd0);
    pre_edge();
    check("byp_a_same", rd_a[63:32], 32'h1234_5678);
    check("byp_b_same", rd_b[63:32], 32'h1000_0007);
    post_edge();
    set_in(1'b0, 8'd0, 32'h0, 8'd0, 8'd7, 8'd0, 8'd0);
    pre_edge();
    check("byp_a_next", rd_a[63:32], 32'h1234_5678);
    check("byp_b_next", rd_b[63:32], 32'h1234_5678);
    post_edge();

    set_in(1'b1, 8'd3, 32'h0000_ABCD, 8'd5, 8'd5, 8'd5, 8'd5);
    pre_edge();
    post_edge();
    for (int p = 0; p < 4; p++) check("rr_prev", {16'h0, rd_c[p*16 +: 16]}, 32'h0000_001D);
    set_in(1'b0, 8'd0, 32'h0, 8'd3, 8'd3, 8'd3, 8'd3);
    pre_edge();
    for (int p = 0; p < 4; p++) check("rr_hold", {16'h0, rd_c[p*16 +: 16]}, 32'h0000_001D);
    post_edge();
    for (int p = 0; p < 4; p++) check("rr_new", {16'h0, rd_c[p*16 +: 16]}, 32'h0000_ABCD);
    set_in(1'b1, 8'd2, 32'h0000_5A5A, 8'd2, 8'd2, 8'd2, 8'd2);
    pre_edge();
    post_edge();
    for (int p = 0; p < 4; p++) check("rr_byp", {16'h0, rd_c[p*16 +: 16]}, 32'h0000_5A5A);

    set_in(1'b1, 8'd5, 32'hDEAD_BEEF, 8'd5, 8'd5, 8'd5, 8'd5);
    pre_edge();
    post_edge();
    set_in(1'b0, 8'd0, 32'h0, 8'd5, 8'd5, 8'd5, 8'd5);
    #2 check("rst_pre", rd_a[31:0], 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1 check_zero("rst_mid");
    #1 rst_n = 1'b1;
    clear_models();
    pre_edge();
    check("rst_r5", rd_a[31:0], 32'h0);
    post_edge();

    for (int n = 0; n < 10000; n++) begin
      set_in(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      pre_edge();
      post_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_nr1w.md
# regfile_nr1w

Parametrised multi-port register file: NUM_REGS entries of WIDTH bits, NUM_RD independent read ports, one synchronous write port. It generalises the fixed 32-entry x 32-bit read select to any depth, width and port count, and adds a hardwired-zero register, write-to-read bypass and an optional registered read stage. It is the register file of the single-cycle and pipelined CPU datapaths.

## Interface
- WIDTH, 32, data width in bits
- NUM_REGS, 32, number of entries; power of two, 2..256
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is ordinary
- BYPASS, 1, 1: a read of the address being written this cycle returns the write data
- READ_REG, 0, 0: combinational reads; 1: read data registered, 1-cycle latency
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write enable
- wr_addr  input  AW=$clog2(NUM_REGS)  write address
- wr_data  input  WIDTH  write data
- rd_addr  input  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  output  NUM_RD*WIDTH  packed read data, port p at [p*WIDTH +: WIDTH]

## Operation
- Reset (rst_n low, asynchronous): every entry cleared to 0; read output registers (READ_REG=1) cleared to 0. Reset dominates clk and wr_en.
- Write: on rising clk with rst_n high and wr_en high, mem[wr_addr] <= wr_data. With ZERO_REG=1 and wr_addr=0 the write is dropped.
- Read, per port p, source value v_p:
  - ZERO_REG=1 and rd_addr_p=0 -> 0 (takes priority over bypass).
  - else BYPASS=1, wr_en=1 and rd_addr_p=wr_addr -> wr_data.
  - else mem[rd_addr_p].
- READ_REG=0: rd_data_p = v_p combinationally. READ_REG=1: rd_data_p <= v_p on each rising clk.
- Ports are independent; any number may address the same entry.
- No out-of-range addresses exist (NUM_REGS is a power of two).

## Timing
- Write takes effect on the clk edge where wr_en is sampled high; visible to a non-bypassed combinational read immediately after that edge.
- READ_REG=0: read latency 0 cycles from rd_addr change. BYPASS=1 gives same-cycle write-to-read forwarding; BYPASS=0 returns the old value until the edge.
- READ_REG=1: rd_data reflects rd_addr/wr_* sampled at the previous edge (latency 1). With BYPASS=1, a read issued in the same cycle as a write to that address returns the new data one cycle later; with BYPASS=0 it returns the old data.
- Reset deasserted mid-stream: first write accepted on the first rising edge with rst_n high; rd_data is 0 until then.
- Reset asserted mid-write: write is lost; entry is 0.

## Structure
- Package regfile_pkg: address-width function (clog2 wrapper), packed-port slice helpers, reset value constant RF_RESET_VAL = 0.
- Sub-module mux_nto1 (parameters WIDTH, N): one per read port, selects mem[rd_addr_p] from the flattened storage array; bypass/zero logic and optional output register live in regfile_nr1w.
- Storage is a flat WIDTH x NUM_REGS register array with the asynchronous reset; no memory macro inference.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n low mid-cycle -> all ports read 0 immediately, r5 reads 0 after release.
- Write/read all entries (default params): write r[i] = 0x1000_0000 + i for i=1..31 -> both ports read back correctly in any address combination; r0 reads 0.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data for address 0 stays 0; with ZERO_REG=0 it reads 0xFFFFFFFF next cycle.
- Bypass: same cycle wr_addr=7, wr_data=0x12345678, rd_addr port1=7 -> BYPASS=1 shows 0x12345678 same cycle; BYPASS=0 shows prior value until the edge.
- Registered read (READ_REG=1, NUM_RD=4, WIDTH=16, NUM_REGS=8): read r3=0xABCD on all ports -> each shows 0xABCD exactly one cycle after address applied.
- Random: 10k cycles random wr_en/addresses/data against a reference model across parameter sets {32,32,2}, {16,8,4}, {8,256,1} -> zero mismatches.
